multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset processor datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath mux select: register-destination 5-bit mux, ALU-source and memory-to-register 32-bit muxes, address and PC-source muxes. Drives register, PC, IR and memory enables, with a ready handshake and timeout towards memory.

---
 rtl/mc_ctrl_pkg.sv | 87 ++++++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/mc_ctrl_wait_timer.sv | 23 ++
 rtl/multicycle_ctrl.sv | 99 +++++++++
 tb/tb_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, mux selects
// and the per-state control word decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EXEC  = 4'd7,
    S_R_WB    = 4'd8,
    S_I_EXEC  = 4'd9,
    S_I_WB    = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // fetch_load marks the FETCH loads (IR and PC) that still need mem_ready
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch_load;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal_op;
    logic       mem_wait;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c           = '0;
    c.alu_src_b = SRCB_REG;
    c.alu_op    = ALU_ADD;
    c.pc_src    = PC_ALU;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.fetch_load = 1'b1; c.alu_src_b = SRCB_FOUR; c.mem_wait = 1'b1; end
      S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      S_MEM_RD:  begin c.mem_read = 1'b1; c.iord = 1'b1; c.mem_wait = 1'b1; end
      S_MEM_WB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:  begin c.mem_write = 1'b1; c.iord = 1'b1; c.mem_wait = 1'b1; end
      S_R_EXEC:  begin c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT; end
      S_R_WB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_I_EXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      S_I_WB:    c.reg_write = 1'b1;
      S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = PC_ALUOUT; c.pc_write_cond = 1'b1; end
      S_JUMP:    begin c.pc_src = PC_JUMP; c.pc_write = 1'b1; end
      S_TRAP:    c.illegal_op = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath side.
interface multicycle_ctrl_if #(parameter int OP_W = 6);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;
  logic            mem_read;
  logic            mem_write;
  logic            iord;
  logic            ir_write;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_src;
  logic            pc_en;
  logic            illegal_op;
  logic            bus_err;
  logic [3:0]      state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, bus_err, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, bus_err, state_o
  );
endinterface

// File: rtl/mc_ctrl_wait_timer.sv
// Memory wait counter: clears, or counts stalled cycles; flags when the
// count has reached MEM_TIMEOUT.
module mc_ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clr)   count <= '0;
    else if (inc)   count <= count + CNT_W'(1);
  end

  assign timeout = (count == CNT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM. Optional bne support is enabled by
// defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int OP_W        = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  state_t          state, state_nx;
  ctrl_t           ctrl;
  logic            bne_q;
  logic            timeout, expired, wait_inc;
  logic [OP_W-1:0] op;

  assign op       = bus.opcode;
  assign wait_inc = ctrl.mem_wait & ~bus.mem_ready & ~timeout;
  assign expired  = ctrl.mem_wait & ~bus.mem_ready & timeout;

  // Any cycle that is not a continued stall restarts the count, which covers
  // entry into a wait state as well as the FETCH retry after a timeout.
  mc_ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~wait_inc),
    .inc     (wait_inc),
    .timeout (timeout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) state_nx = S_MEM_ADR;
        else if (op == OP_W'(OP_RTYPE))              state_nx = S_R_EXEC;
        else if (op == OP_W'(OP_ADDI))               state_nx = S_I_EXEC;
        else if (op == OP_W'(OP_BEQ))                state_nx = S_BRANCH;
        else if (op == OP_W'(OP_J))                  state_nx = S_JUMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
        else if (op == OP_W'(OP_BNE))                state_nx = S_BRANCH;
`endif
        else                                         state_nx = S_TRAP;
      end
      S_MEM_ADR: state_nx = (op == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (bus.mem_ready) state_nx = S_MEM_WB;
                 else if (expired)  state_nx = S_FETCH;
      S_MEM_WR:  if (bus.mem_ready || expired) state_nx = S_FETCH;
      S_R_EXEC:  state_nx = S_R_WB;
      S_I_EXEC:  state_nx = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_TRAP: state_nx = S_FETCH;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Control word is registered alongside the state so reset clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_nx;
      ctrl  <= state_ctrl(state_nx);
    end
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 bne_q <= 1'b0;
    else if (state == S_DECODE) bne_q <= (op == OP_W'(OP_BNE));
  end
`else
  assign bne_q = 1'b0;
`endif

  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.iord       = ctrl.iord;
  assign bus.ir_write   = ctrl.fetch_load & bus.mem_ready;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.pc_en      = ctrl.pc_write
                        | (ctrl.fetch_load & bus.mem_ready)
                        | (ctrl.pc_write_cond & (bus.zero ^ bne_q));
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.bus_err    = expired;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized and directed bench for multicycle_ctrl against an
// instruction-route model; honours MULTICYCLE_CTRL_BNE_EN.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  localparam int TO = 15;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  // Model: current step, remaining route of the instruction, stall count.
  state_t m_st = S_IDLE;
  int     m_cnt = 0;
  logic   m_bne = 1'b0;
  state_t sched[$];

  logic [3:0] s_st;
  logic       s_berr, s_ill, s_pcen, s_mw, s_rw, s_rd, s_m2r;
  logic [1:0] s_pcsrc;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OP_W(6)) bus();
  multicycle_ctrl #(.MEM_TIMEOUT(TO), .OP_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic enter(input state_t s);
    m_st  = s;
    m_cnt = 0;
  endtask

  task automatic advance();
    if (sched.size() > 0) enter(sched.pop_front());
    else                  enter(S_FETCH);
  endtask

  task automatic reset_model();
    m_st = S_IDLE; m_cnt = 0; m_bne = 1'b0; sched.delete();
  endtask

  task automatic model_step();
    if (!rst_n) begin
      reset_model();
      return;
    end
    case (m_st)
      S_IDLE: enter(S_FETCH);
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) begin
          if (m_st == S_FETCH) enter(S_DECODE);
          else                 advance();
        end else if (m_cnt == TO) begin
          sched.delete();
          enter(S_FETCH);
        end else m_cnt++;
      end
      S_DECODE: begin
        m_bne = 1'b0;
        case (bus.opcode)
          6'b100011: sched = '{S_MEM_ADR, S_MEM_RD, S_MEM_WB};
          6'b101011: sched = '{S_MEM_ADR, S_MEM_WR};
          6'b000000: sched = '{S_R_EXEC, S_R_WB};
          6'b001000: sched = '{S_I_EXEC, S_I_WB};
          6'b000100: sched = '{S_BRANCH};
          6'b000010: sched = '{S_JUMP};
          6'b000101: if (BNE_EN) begin sched = '{S_BRANCH}; m_bne = 1'b1; end
                     else sched = '{S_TRAP};
          default:   sched = '{S_TRAP};
        endcase
        advance();
      end
      default: advance();
    endcase
  endtask

  task automatic check_all();
    logic mr, mw, io, irw, rw, rd, m2r, asa, pce, ill, be, rdy;
    logic [1:0] asb, aop, pcs;
    rdy = bus.mem_ready;
    {mr, mw, io, irw, rw, rd, m2r, asa, pce, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    be = (m_st inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !rdy && (m_cnt == TO);
    case (m_st)
      S_FETCH:   begin mr = 1; asb = 2'b01; irw = rdy; pce = rdy; end
      S_DECODE:  asb = 2'b11;
      S_MEM_ADR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:  begin mr = 1; io = 1; end
      S_MEM_WB:  begin rw = 1; m2r = 1; end
      S_MEM_WR:  begin mw = 1; io = 1; end
      S_R_EXEC:  begin asa = 1; aop = 2'b10; end
      S_R_WB:    begin rw = 1; rd = 1; end
      S_I_EXEC:  begin asa = 1; asb = 2'b10; end
      S_I_WB:    rw = 1;
      S_BRANCH:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pce = bus.zero ^ m_bne; end
      S_JUMP:    begin pcs = 2'b10; pce = 1; end
      S_TRAP:    ill = 1;
      default:   ;
    endcase
    chk("state_o", bus.state_o, m_st);
    chk("mem_read", bus.mem_read, mr);
    chk("mem_write", bus.mem_write, mw);
    chk("iord", bus.iord, io);
    chk("ir_write", bus.ir_write, irw);
    chk("reg_write", bus.reg_write, rw);
    chk("reg_dst", bus.reg_dst, rd);
    chk("mem_to_reg", bus.mem_to_reg, m2r);
    chk("alu_src_a", bus.alu_src_a, asa);
    chk("alu_src_b", bus.alu_src_b, asb);
    chk("alu_op", bus.alu_op, aop);
    chk("pc_src", bus.pc_src, pcs);
    chk("pc_en", bus.pc_en, pce);
    chk("illegal_op", bus.illegal_op, ill);
    chk("bus_err", bus.bus_err, be);
  endtask

  // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step();
    #4;
    check_all();
    s_st = bus.state_o; s_berr = bus.bus_err; s_ill = bus.illegal_op;
    s_pcen = bus.pc_en; s_pcsrc = bus.pc_src; s_mw = bus.mem_write;
    s_rw = bus.reg_write; s_rd = bus.reg_dst; s_m2r = bus.mem_to_reg;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, output int lat);
    bus.opcode = op; bus.zero = 1'b0; bus.mem_ready = 1'b1; lat = 0;
    do begin step(); lat++; end while (bus.state_o != S_FETCH && lat < 40);
  endtask

  task automatic branch_case(input logic [5:0] op, input logic z, input logic exp_pcen);
    bus.opcode = op; bus.zero = z; bus.mem_ready = 1'b1;
    step(); step(); step();
    chk("branch_state", s_st, S_BRANCH);
    chk("branch_pc_en", s_pcen, exp_pcen);
    chk("branch_pc_src", s_pcsrc, 2'b01);
    chk("branch_return", bus.state_o, S_FETCH);
  endtask

  initial begin
    logic [5:0] lat_ops [7];
    int         lat_exp [7];
    logic [3:0] seen [5];
    logic [3:0] seq_exp [5];
    int lat, cnt, rd_cyc, berr_cnt, wr_cyc, berr_at, overlap, ill_cnt, wb_ok;
    int fstall;
    logic mstall;

    bus.opcode = 6'b000000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    step();
    chk("reset_state", s_st, S_IDLE);

    // R-type walk-through from reset release
    rst_n = 1'b1;
    seq_exp = '{S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB};
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen[i] = s_st;
      if (s_rw && s_rd) cnt++;
    end
    for (int i = 0; i < 5; i++) chk("rtype_seq", seen[i], seq_exp[i]);
    chk("rtype_regdst_cycles", cnt, 1);
    chk("rtype_back_fetch", bus.state_o, S_FETCH);

    lat_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b111111};
    lat_exp = '{5, 4, 4, 4, 3, 3, 3};
    for (int i = 0; i < 7; i++) begin
      run_instr(lat_ops[i], lat);
      chk("latency", lat, lat_exp[i]);
    end

    // lw with three stalled MEM_RD cycles
    bus.opcode = 6'b100011; cnt = 0; rd_cyc = 0; berr_cnt = 0; wb_ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.state_o == S_MEM_RD && cnt < 3) begin bus.mem_ready = 1'b0; cnt++; end
      else bus.mem_ready = 1'b1;
      step();
      if (s_st == S_MEM_RD) rd_cyc++;
      if (s_st == S_MEM_WB && s_m2r && s_rw && !s_rd) wb_ok++;
      berr_cnt += int'(s_berr);
      if (bus.state_o == S_FETCH) break;
    end
    chk("lw_memrd_cycles", rd_cyc, 4);
    chk("lw_memwb_ok", wb_ok, 1);
    chk("lw_no_bus_err", berr_cnt, 0);

    branch_case(6'b000100, 1'b1, 1'b1);
    branch_case(6'b000100, 1'b0, 1'b0);

    // sw stalls until timeout
    bus.opcode = 6'b101011; wr_cyc = 0; berr_at = 0; overlap = 0;
    for (int i = 0; i < 60; i++) begin
      bus.mem_ready = (bus.state_o == S_MEM_WR) ? 1'b0 : 1'b1;
      step();
      if (s_st == S_MEM_WR) wr_cyc++;
      if (s_mw && s_rw) overlap++;
      if (s_berr) begin berr_at = wr_cyc; break; end
    end
    chk("sw_bus_err_cycle", berr_at, 16);
    chk("sw_after_timeout", bus.state_o, S_FETCH);
    chk("sw_overlap", overlap, 0);

    // illegal opcode
    bus.opcode = 6'b111111; bus.mem_ready = 1'b1; ill_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      ill_cnt += int'(s_ill);
    end
    chk("illegal_pulse_cycles", ill_cnt, 1);
    chk("illegal_back_fetch", bus.state_o, S_FETCH);

    if (BNE_EN) begin
      branch_case(6'b000101, 1'b0, 1'b1);
      branch_case(6'b000101, 1'b1, 1'b0);
    end else begin
      bus.opcode = 6'b000101;
      step(); step();
      chk("bne_disabled_trap", bus.state_o, S_TRAP);
      step();
    end

    // asynchronous reset in the middle of a store
    bus.opcode = 6'b101011; cnt = 0;
    while (bus.state_o != S_MEM_WR && cnt < 10) begin
      bus.mem_ready = 1'b1;
      step();
      cnt++;
    end
    bus.mem_ready = 1'b0;
    #2;
    chk("mw_before_reset", bus.mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mw_async_drop", bus.mem_write, 1'b0);
    chk("reset_async_state", bus.state_o, S_IDLE);
    reset_model();
    @(posedge clk); #1;
    rst_n = 1'b1; bus.mem_ready = 1'b1;
    step();
    chk("post_reset_idle", s_st, S_IDLE);
    chk("post_reset_fetch", bus.state_o, S_FETCH);

    // randomized traffic
    fstall = 0; mstall = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (m_st == S_FETCH) begin
        case ($urandom_range(0, 7))
          0: bus.opcode = 6'b100011;
          1: bus.opcode = 6'b101011;
          2: bus.opcode = 6'b000000;
          3: bus.opcode = 6'b001000;
          4: bus.opcode = 6'b000100;
          5: bus.opcode = 6'b000101;
          6: bus.opcode = 6'b000010;
          default: bus.opcode = 6'($urandom_range(0, 63));
        endcase
      end
      if (m_st == S_DECODE) begin
        mstall = ($urandom_range(0, 7) == 0);
        fstall = ($urandom_range(0, 15) == 0) ? 20 : 0;
      end
      bus.zero = 1'($urandom_range(0, 1));
      if (m_st == S_FETCH && fstall > 0) begin
        bus.mem_ready = 1'b0;
        fstall--;
      end else if ((m_st == S_MEM_RD || m_st == S_MEM_WR) && mstall)
        bus.mem_ready = 1'b0;
      else
        bus.mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
